// File: rtl/pipe_pkg.sv
// Shared MEM/WB pipeline definitions: bundle layout, default widths and a width helper.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_W_DEF   = 5;

  // Field order {o, d, rd, w_reg, lw}; modules with non-default widths declare the same layout locally.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] o;
    logic [DATA_W_DEF-1:0] d;
    logic [RD_W_DEF-1:0]   rd;
    logic                  wReg;
    logic                  lw;
  } mwBundle_t;

  function automatic int unsigned mwBundleWidth(input int unsigned dataW, input int unsigned rdW);
    return 2 * dataW + rdW + 2;
  endfunction

endpackage

// File: rtl/skid_reg.sv
// Generic 2-entry skid buffer: main entry drives the output, skid entry absorbs one bundle on stall.
module skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  logic             mValid, sValid;
  logic [WIDTH-1:0] mData, sData;
  logic             mValidNext, sValidNext;
  logic [WIDTH-1:0] mDataNext, sDataNext;
  logic             accept, pop;

  assign accept   = inValid && inReady;
  assign pop      = mValid && outReady;
  assign outValid = mValid;
  assign outData  = mData;

  always_comb begin
    mValidNext = mValid;
    sValidNext = sValid;
    mDataNext  = mData;
    sDataNext  = sData;
    if (flush) begin
      // Valid bits only; data fields are left as they were.
      mValidNext = 1'b0;
      sValidNext = 1'b0;
    end else if (pop) begin
      if (sValid) begin
        mDataNext  = sData;
        sValidNext = 1'b0;
      end else if (accept) begin
        mDataNext = inData;
      end else begin
        mValidNext = 1'b0;
      end
    end else if (accept) begin
      if (!mValid) begin
        mDataNext  = inData;
        mValidNext = 1'b1;
      end else begin
        sDataNext  = inData;
        sValidNext = 1'b1;
      end
    end
  end

  // inReady is a register so WB backpressure never reaches MEM combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      mValid  <= 1'b0;
      sValid  <= 1'b0;
      mData   <= '0;
      sData   <= '0;
      inReady <= 1'b0;
    end else begin
      mValid  <= mValidNext;
      sValid  <= sValidNext;
      mData   <= mDataNext;
      sData   <= sDataNext;
      inReady <= !sValidNext;
    end
  end

endmodule

// File: rtl/mw_skid_latch.sv
// MEM/WB pipeline latch with valid/ready skid buffering and synchronous flush.
// Optional WB stall counter enabled by defining STALL_CNT_EN.
module mw_skid_latch
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RD_W   = RD_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] o_in,
  input  logic [DATA_W-1:0] d_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic              w_reg_in,
  input  logic              lw_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] o_out,
  output logic [DATA_W-1:0] d_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              w_reg_out,
  output logic              lw_out
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int unsigned BUNDLE_W = mwBundleWidth(DATA_W, RD_W);

  typedef struct packed {
    logic [DATA_W-1:0] o;
    logic [DATA_W-1:0] d;
    logic [RD_W-1:0]   rd;
    logic              wReg;
    logic              lw;
  } bundle_t;

  bundle_t              bundleIn, bundleOut;
  logic [BUNDLE_W-1:0]  busIn, busOut;

  assign bundleIn = '{o: o_in, d: d_in, rd: rd_in, wReg: w_reg_in, lw: lw_in};
  assign busIn    = bundleIn;
  assign bundleOut = busOut;

  skid_reg #(
    .WIDTH(BUNDLE_W)
  ) uSkid (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .inValid (in_valid),
    .inReady (in_ready),
    .inData  (busIn),
    .outValid(out_valid),
    .outReady(out_ready),
    .outData (busOut)
  );

  // Control bits are gated so an empty slot can never write the register file.
  assign o_out     = bundleOut.o;
  assign d_out     = bundleOut.d;
  assign rd_out    = bundleOut.rd;
  assign w_reg_out = out_valid & bundleOut.wReg;
  assign lw_out    = out_valid & bundleOut.lw;

`ifdef STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mw_skid_latch.sv
// Directed self-checking bench for mw_skid_latch (stall counter checks run when STALL_CNT_EN is defined).
module tb_mw_skid_latch;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, w_reg_in, lw_in, w_reg_out, lw_out;
  logic [31:0] o_in, d_in, o_out, d_out;
  logic [4:0]  rd_in, rd_out;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mw_skid_latch #(
    .DATA_W(32),
    .RD_W  (5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o_in     (o_in),
    .d_in     (d_in),
    .rd_in    (rd_in),
    .w_reg_in (w_reg_in),
    .lw_in    (lw_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o_out    (o_out),
    .d_out    (d_out),
    .rd_out   (rd_out),
    .w_reg_out(w_reg_out),
    .lw_out   (lw_out)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] o, input logic [31:0] d,
                       input logic [4:0] rd, input logic w, input logic l);
    in_valid = v; o_in = o; d_in = d; rd_in = rd; w_reg_in = w; lw_in = l;
  endtask

  task automatic chkOut(input string tag, input logic v, input logic [31:0] o,
                        input logic [31:0] d, input logic [4:0] rd, input logic w, input logic l);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".o"}, o_out, o);
    chk({tag, ".d"}, d_out, d);
    chk({tag, ".rd"}, rd_out, rd);
    chk({tag, ".wreg"}, w_reg_out, w);
    chk({tag, ".lw"}, lw_out, l);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    #1;

    // 1: reset
    step(); step();
    chkOut("rst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    chk("rst.in_ready", in_ready, 1'b0);
    reset = 1'b0;
    step();
    chk("rel.in_ready", in_ready, 1'b1);
    chk("rel.valid", out_valid, 1'b0);

    // 2: streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'h10 + i, 32'h20 + i, 5'(i), 1'b1, i[0]);
      step();
      chkOut($sformatf("stream%0d", i), 1'b1, 32'h10 + i, 32'h20 + i, 5'(i), 1'b1, i[0]);
      chk($sformatf("stream%0d.in_ready", i), in_ready, 1'b1);
    end
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    chk("stream.drain", out_valid, 1'b0);

    // 3: backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
    step();
    chkOut("bpA", 1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
    chk("bpA.in_ready", in_ready, 1'b1);
    drive(1'b1, 32'hB0, 32'hB1, 5'd11, 1'b1, 1'b1);
    step();
    chkOut("bpB", 1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
    chk("bpB.in_ready", in_ready, 1'b0);
    drive(1'b1, 32'hC0, 32'hC1, 5'd12, 1'b0, 1'b1);
    step();
    chkOut("bpC.hold", 1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b0);
    chk("bpC.in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    step();
    chkOut("bp.outB", 1'b1, 32'hB0, 32'hB1, 5'd11, 1'b1, 1'b1);
    chk("bp.outB.in_ready", in_ready, 1'b1);
    step();
    chkOut("bp.outC", 1'b1, 32'hC0, 32'hC1, 5'd12, 1'b0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    chk("bp.drain", out_valid, 1'b0);

    // 4: flush while full with C presented
    out_ready = 1'b0;
    drive(1'b1, 32'hA0, 32'hA1, 5'd10, 1'b1, 1'b1);
    step();
    drive(1'b1, 32'hB0, 32'hB1, 5'd11, 1'b1, 1'b1);
    step();
    chk("fl.full.in_ready", in_ready, 1'b0);
    drive(1'b1, 32'hC0, 32'hC1, 5'd12, 1'b1, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chkOut("fl", 1'b0, 32'hA0, 32'hA1, 5'd10, 1'b0, 1'b0);
    chk("fl.in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    drive(1'b1, 32'hD0, 32'hD1, 5'd0, 1'b1, 1'b0);
    step();
    chkOut("fl.D", 1'b1, 32'hD0, 32'hD1, 5'd0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    step();
    chk("fl.Dalone", out_valid, 1'b0);

    // 5: gating of an emptied slot
    out_ready = 1'b0;
    drive(1'b1, 32'hE0, 32'hE1, 5'd7, 1'b1, 1'b1);
    step();
    chkOut("gateE", 1'b1, 32'hE0, 32'hE1, 5'd7, 1'b1, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chkOut("gate.pop", 1'b0, 32'hE0, 32'hE1, 5'd7, 1'b0, 1'b0);

`ifdef STALL_CNT_EN
    // 6: stall counter (4 stall edges accumulated above)
    chk("sc.prior", stall_cnt, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sc.reset0", stall_cnt, 32'd0);
    step();
    out_ready = 1'b0;
    drive(1'b1, 32'hF0, 32'hF1, 5'd3, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step();
    out_ready = 1'b1;
    step();
    chk("sc.seven", stall_cnt, 32'd7);
    chk("sc.popped", out_valid, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sc.flush", stall_cnt, 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("sc.reset", stall_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
